alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-driven controller that sits in front of the 4-bit combinational ALU and drives its operand and select inputs. It accepts one command at a time over a valid/ready handshake and holds a small register file. It presents the operands to the ALU, captures the ALU result and flags, writes the result back, and returns a response over a second valid/ready handshake.

## Interface
Parameters:
- NREG, 4: number of 4-bit registers; power of two, at least 2. IW = log2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE and rst low
- cmd_ld  in  1  1 = load immediate, 0 = ALU operation
- cmd_op  in  3  ALU select code, ignored when cmd_ld=1
- cmd_dst  in  IW  destination register index
- cmd_srca  in  IW  operand A register index
- cmd_srcb  in  IW  operand B register index
- cmd_imm  in  4  immediate for load
- alu_a  out  4  registered, to ALU A
- alu_b  out  4  registered, to ALU B
- alu_s  out  3  registered, to ALU select
- alu_y  in  4  ALU result
- alu_cout  in  1  ALU carry / shifted-out bit
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  4  result written to cmd_dst
- rsp_cout  out  1  captured carry
- rsp_zero  out  1  captured zero

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command.
  - ALU command: load alu_a=reg[srca], alu_b=reg[srcb], alu_s=cmd_op, then go to EXEC.
  - Load command: write reg[dst]=imm, set rsp_y=imm, rsp_cout=0, rsp_zero=(imm==0), then go to RESP.
- EXEC: one cycle.
  - The ALU settles combinationally on the registered alu_a/b/s.
  - At the closing edge: reg[dst]=alu_y, rsp_y=alu_y, rsp_cout=alu_cout, rsp_zero=alu_zero, then go to RESP.
- RESP:
  - rsp_valid=1, with rsp_y/rsp_cout/rsp_zero held stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid and cmd_ready are never high in the same cycle.
- Register reads in IDLE see all earlier writes, because the previous response has completed.
- srca, srcb and dst may be equal.
- Operands are read at acceptance; the write occurs later.
- alu_a/b/s hold their last value outside EXEC; they are not cleared.
- The register file is not otherwise readable. Registers change only through commands.
- Reset values:
  - state=IDLE; all registers 0.
  - alu_a=0, alu_b=0, alu_s=0.
  - rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_zero=0.
  - cmd_ready=0 while rst is high.
- Reset mid-EXEC or mid-RESP:
  - The command is abandoned and no write-back occurs.
  - An unconsumed response is dropped.

## Timing
- Handshake: a transfer happens on a rising edge where valid and ready are both high.
- Command inputs must be stable only on the accept edge.
- ALU command accepted at edge N:
  - alu_* valid after N.
  - Capture at N+1.
  - rsp_valid high after N+1.
  - Earliest next accept at N+3 if rsp_ready is held high.
- Load accepted at edge N: rsp_valid high after N; earliest next accept at N+2.
- rsp_valid, once high, stays high with stable data until accepted.
- The ALU is a single-cycle combinational path alu_a/b/s → alu_y/cout/zero. It must meet one clock period.

## Structure
- Shared package alu_seq_pkg:
  - Opcode constants: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_SHL=110, OP_SHR=111.
  - FSM state encoding.
- One sub-module, alu_seq_regfile:
  - NREG×4 flops.
  - Two combinational read ports and one synchronous write port with enable.
  - Async reset to 0.
- The ALU is instantiated outside this block, one level up.

## Test plan
- Load r0=9, load r1=8, ADD dst=r2 srca=r0 srcb=r1 → rsp_y=0001, rsp_cout=1, rsp_zero=0. A later ADD r3=r2+r2 → rsp_y=0010.
- Load r0=5, SUB r1=r0−r0 → rsp_y=0000, rsp_cout=1, rsp_zero=1. Load imm=0 → rsp_zero=1, rsp_cout=0.
- Load r0=1001:
  - SHL r1=r0 → rsp_y=0010, rsp_cout=1.
  - SHR r2=r0 → rsp_y=0100, rsp_cout=1.
  - NOT r3=r0 → rsp_y=0110.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid and rsp_y stay stable, and cmd_ready=0 throughout. With cmd_valid held high, the next command is accepted the edge after the response transfer.
- Reset mid-op:
  - Load r0=0111, accept ADD r0=r0+r0, then assert rst during EXEC.
  - After release: rsp_valid=0, cmd_ready=1, and r0 reads 0 (check via ADD r1=r0+r0 → rsp_y=0, rsp_zero=1).
- Cycle check: an ALU command accepted at edge N with rsp_ready tied high gives rsp_valid high for exactly one cycle after N+1, and cmd_ready=1 again after N+2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants and FSM state encoding.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StResp = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x 4-bit register file: two combinational read ports, one synchronous write port.
module alu_seq_regfile #(
   parameter  int unsigned NREG = 4,
   localparam int unsigned IW   = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  logic [3:0]    i_wdata,
   input  logic [IW-1:0] i_raddr_a,
   input  logic [IW-1:0] i_raddr_b,
   output logic [3:0]    o_rdata_a,
   output logic [3:0]    o_rdata_b
);

   logic [3:0] r_mem [NREG];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            r_mem[i] <= 4'd0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven controller feeding an external 4-bit combinational ALU, with a small
// register file and valid/ready command and response handshakes.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter  int unsigned NREG = 4,
   localparam int unsigned IW   = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_ld,
   input  logic [2:0]    i_cmd_op,
   input  logic [IW-1:0] i_cmd_dst,
   input  logic [IW-1:0] i_cmd_srca,
   input  logic [IW-1:0] i_cmd_srcb,
   input  logic [3:0]    i_cmd_imm,
   output logic [3:0]    o_alu_a,
   output logic [3:0]    o_alu_b,
   output logic [2:0]    o_alu_s,
   input  logic [3:0]    i_alu_y,
   input  logic          i_alu_cout,
   input  logic          i_alu_zero,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [3:0]    o_rsp_y,
   output logic          o_rsp_cout,
   output logic          o_rsp_zero
);

   seq_state_e    r_state, w_state_d;
   logic [3:0]    r_alu_a, r_alu_b;
   logic [2:0]    r_alu_s;
   logic [IW-1:0] r_dst;
   logic [3:0]    r_rsp_y;
   logic          r_rsp_cout, r_rsp_zero;

   logic [3:0]    w_rdata_a, w_rdata_b;
   logic          w_we;
   logic [IW-1:0] w_waddr;
   logic [3:0]    w_wdata;
   logic          w_ld_alu, w_ld_rsp;
   logic [3:0]    w_rsp_y_d;
   logic          w_rsp_cout_d, w_rsp_zero_d;

   alu_seq_regfile #(
      .NREG (NREG)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (i_cmd_srca),
      .i_raddr_b (i_cmd_srcb),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // The single write port is shared: immediate loads write in IDLE, ALU results in EXEC.
   always_comb begin
      w_state_d    = r_state;
      w_we         = 1'b0;
      w_waddr      = r_dst;
      w_wdata      = i_alu_y;
      w_ld_alu     = 1'b0;
      w_ld_rsp     = 1'b0;
      w_rsp_y_d    = i_alu_y;
      w_rsp_cout_d = i_alu_cout;
      w_rsp_zero_d = i_alu_zero;
      unique case (r_state)
         StIdle: begin
            if (i_cmd_valid) begin
               if (i_cmd_ld) begin
                  w_we         = 1'b1;
                  w_waddr      = i_cmd_dst;
                  w_wdata      = i_cmd_imm;
                  w_ld_rsp     = 1'b1;
                  w_rsp_y_d    = i_cmd_imm;
                  w_rsp_cout_d = 1'b0;
                  w_rsp_zero_d = (i_cmd_imm == 4'd0);
                  w_state_d    = StResp;
               end else begin
                  w_ld_alu  = 1'b1;
                  w_state_d = StExec;
               end
            end
         end
         StExec: begin
            w_we      = 1'b1;
            w_ld_rsp  = 1'b1;
            w_state_d = StResp;
         end
         StResp: begin
            if (i_rsp_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_alu_a    <= 4'd0;
         r_alu_b    <= 4'd0;
         r_alu_s    <= 3'd0;
         r_dst      <= '0;
         r_rsp_y    <= 4'd0;
         r_rsp_cout <= 1'b0;
         r_rsp_zero <= 1'b0;
      end else begin
         if (w_ld_alu) begin
            r_alu_a <= w_rdata_a;
            r_alu_b <= w_rdata_b;
            r_alu_s <= i_cmd_op;
            r_dst   <= i_cmd_dst;
         end
         if (w_ld_rsp) begin
            r_rsp_y    <= w_rsp_y_d;
            r_rsp_cout <= w_rsp_cout_d;
            r_rsp_zero <= w_rsp_zero_d;
         end
      end
   end

   assign o_cmd_ready = (r_state == StIdle) && !i_rst;
   assign o_rsp_valid = (r_state == StResp);
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_s     = r_alu_s;
   assign o_rsp_y     = r_rsp_y;
   assign o_rsp_cout  = r_rsp_cout;
   assign o_rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU closing the loop.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic       i_cmd_ld = 1'b0;
   logic [2:0] i_cmd_op = 3'd0;
   logic [1:0] i_cmd_dst = 2'd0;
   logic [1:0] i_cmd_srca = 2'd0;
   logic [1:0] i_cmd_srcb = 2'd0;
   logic [3:0] i_cmd_imm = 4'd0;
   logic [3:0] o_alu_a, o_alu_b;
   logic [2:0] o_alu_s;
   logic [3:0] w_alu_y;
   logic       w_alu_cout, w_alu_zero;
   logic       o_rsp_valid;
   logic       i_rsp_ready = 1'b0;
   logic [3:0] o_rsp_y;
   logic       o_rsp_cout, o_rsp_zero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 i_clk = ~i_clk;

   alu_sequencer #(
      .NREG (4)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_ld    (i_cmd_ld),
      .i_cmd_op    (i_cmd_op),
      .i_cmd_dst   (i_cmd_dst),
      .i_cmd_srca  (i_cmd_srca),
      .i_cmd_srcb  (i_cmd_srcb),
      .i_cmd_imm   (i_cmd_imm),
      .o_alu_a     (o_alu_a),
      .o_alu_b     (o_alu_b),
      .o_alu_s     (o_alu_s),
      .i_alu_y     (w_alu_y),
      .i_alu_cout  (w_alu_cout),
      .i_alu_zero  (w_alu_zero),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_y     (o_rsp_y),
      .o_rsp_cout  (o_rsp_cout),
      .o_rsp_zero  (o_rsp_zero)
   );

   // SUB carry is the inverted borrow; logic ops clear carry; shifts return the bit shifted out.
   always_comb begin
      w_alu_y    = 4'd0;
      w_alu_cout = 1'b0;
      case (o_alu_s)
         OP_ADD: {w_alu_cout, w_alu_y} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
         OP_SUB: {w_alu_cout, w_alu_y} = {1'b0, o_alu_a} + {1'b0, ~o_alu_b} + 5'd1;
         OP_AND: w_alu_y = o_alu_a & o_alu_b;
         OP_OR:  w_alu_y = o_alu_a | o_alu_b;
         OP_XOR: w_alu_y = o_alu_a ^ o_alu_b;
         OP_NOT: w_alu_y = ~o_alu_a;
         OP_SHL: {w_alu_cout, w_alu_y} = {o_alu_a, 1'b0};
         OP_SHR: begin
            w_alu_y    = {1'b0, o_alu_a[3:1]};
            w_alu_cout = o_alu_a[0];
         end
         default: w_alu_y = 4'd0;
      endcase
      w_alu_zero = (w_alu_y == 4'd0);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_cmd(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm);
      i_cmd_ld   = ld;
      i_cmd_op   = op;
      i_cmd_dst  = dst;
      i_cmd_srca = sa;
      i_cmd_srcb = sb;
      i_cmd_imm  = imm;
   endtask

   // Issue one command, wait for its response, check it and consume it.
   task automatic do_cmd(input string tag, input logic ld, input logic [2:0] op,
                         input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] imm, input logic [3:0] ey, input logic ec,
                         input logic ez);
      int n;
      @(negedge i_clk);
      set_cmd(ld, op, dst, sa, sb, imm);
      i_cmd_valid = 1'b1;
      n = 0;
      while (!o_cmd_ready && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_cmd_ready) begin
         check({tag, "_accept_timeout"}, o_cmd_ready, 1);
         i_cmd_valid = 1'b0;
         return;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      n = 0;
      while (!o_rsp_valid && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_rsp_valid) begin
         check({tag, "_rsp_timeout"}, o_rsp_valid, 1);
         return;
      end
      check({tag, "_y"}, o_rsp_y, ey);
      check({tag, "_cout"}, o_rsp_cout, ec);
      check({tag, "_zero"}, o_rsp_zero, ez);
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
   endtask

   initial begin
      logic [3:0] held_y;

      // Reset state
      #12;
      check("rst_cmd_ready", o_cmd_ready, 0);
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_alu_a", o_alu_a, 0);
      check("rst_alu_b", o_alu_b, 0);
      check("rst_alu_s", o_alu_s, 0);
      check("rst_rsp_y", o_rsp_y, 0);
      check("rst_rsp_flags", {o_rsp_cout, o_rsp_zero}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1 check("idle_cmd_ready", o_cmd_ready, 1);

      // Loads and ADD with carry-out
      do_cmd("ld_r0_9", 1, OP_ADD, 0, 0, 0, 4'd9, 4'd9, 0, 0);
      do_cmd("ld_r1_8", 1, OP_ADD, 1, 0, 0, 4'd8, 4'd8, 0, 0);
      do_cmd("add_r2", 0, OP_ADD, 2, 0, 1, 4'd0, 4'd1, 1, 0);
      do_cmd("add_r3", 0, OP_ADD, 3, 2, 2, 4'd0, 4'd2, 0, 0);

      // SUB to zero, zero immediate
      do_cmd("ld_r0_5", 1, OP_ADD, 0, 0, 0, 4'd5, 4'd5, 0, 0);
      do_cmd("sub_r1", 0, OP_SUB, 1, 0, 0, 4'd0, 4'd0, 1, 1);
      do_cmd("ld_zero", 1, OP_SUB, 2, 0, 0, 4'd0, 4'd0, 0, 1);

      // Shifts and NOT on 1001
      do_cmd("ld_r0_1001", 1, OP_ADD, 0, 0, 0, 4'b1001, 4'b1001, 0, 0);
      do_cmd("shl_r1", 0, OP_SHL, 1, 0, 0, 4'd0, 4'b0010, 1, 0);
      do_cmd("shr_r2", 0, OP_SHR, 2, 0, 0, 4'd0, 4'b0100, 1, 0);
      do_cmd("not_r3", 0, OP_NOT, 3, 0, 0, 4'd0, 4'b0110, 0, 0);

      // Backpressure: ADD r0=r1+r1 (2+2) held 5 cycles, next command waiting behind it
      @(negedge i_clk);
      set_cmd(0, OP_ADD, 0, 1, 1, 4'd0);
      i_cmd_valid = 1'b1;
      @(negedge i_clk);
      set_cmd(1, OP_ADD, 3, 0, 0, 4'd7);
      @(negedge i_clk);
      check("bp_rsp_valid", o_rsp_valid, 1);
      check("bp_rsp_y", o_rsp_y, 4'd4);
      held_y = o_rsp_y;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("bp_hold_valid", o_rsp_valid, 1);
         check("bp_hold_y", o_rsp_y, held_y);
         check("bp_hold_cmd_ready", o_cmd_ready, 0);
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      check("bp_after_xfer_ready", o_cmd_ready, 1);
      check("bp_after_xfer_valid", o_rsp_valid, 0);
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      check("bp_next_valid", o_rsp_valid, 1);
      check("bp_next_y", o_rsp_y, 4'd7);
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;

      // Reset during EXEC abandons the write-back
      do_cmd("ld_r0_7", 1, OP_ADD, 0, 0, 0, 4'b0111, 4'b0111, 0, 0);
      @(negedge i_clk);
      set_cmd(0, OP_ADD, 0, 0, 0, 4'd0);
      i_cmd_valid = 1'b1;
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      check("mid_in_exec_valid", o_rsp_valid, 0);
      i_rst = 1'b1;
      #1 check("mid_rst_cmd_ready", o_cmd_ready, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("mid_after_valid", o_rsp_valid, 0);
      check("mid_after_ready", o_cmd_ready, 1);
      do_cmd("mid_r0_cleared", 0, OP_ADD, 1, 0, 0, 4'd0, 4'd0, 0, 1);

      // Cycle timing with rsp_ready tied high
      do_cmd("ld_r0_3", 1, OP_ADD, 0, 0, 0, 4'd3, 4'd3, 0, 0);
      @(negedge i_clk);
      i_rsp_ready = 1'b1;
      set_cmd(0, OP_ADD, 1, 0, 0, 4'd0);
      i_cmd_valid = 1'b1;
      @(negedge i_clk);          // after N
      i_cmd_valid = 1'b0;
      check("cyc_n_valid", o_rsp_valid, 0);
      check("cyc_n_ready", o_cmd_ready, 0);
      check("cyc_n_alu_a", o_alu_a, 4'd3);
      check("cyc_n_alu_s", o_alu_s, OP_ADD);
      @(negedge i_clk);          // after N+1
      check("cyc_n1_valid", o_rsp_valid, 1);
      check("cyc_n1_y", o_rsp_y, 4'd6);
      @(negedge i_clk);          // after N+2
      check("cyc_n2_valid", o_rsp_valid, 0);
      check("cyc_n2_ready", o_cmd_ready, 1);
      check("cyc_alu_hold", o_alu_a, 4'd3);
      i_rsp_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
